// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline types for the decode/execute boundary.
// Control bundle layout and forwarding-select encodings.
package id_ex_stage_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef struct packed {
        logic [3:0] alucontrol;
        logic       regwrite;
        logic       alusrc;
        logic       memwrite;
        logic       wdsel;
        logic       resultsrc;
    } ctrl_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding select for one EX source register.
// The youngest producer (MEM) wins over WB; x0 never forwards.
module fwd_unit
    import id_ex_stage_pkg::*;
(
    input  logic       valid,
    input  logic [4:0] rs,
    input  logic [4:0] m_rd,
    input  logic       m_regwrite,
    input  logic [4:0] w_rd,
    input  logic       w_regwrite,
    output logic [1:0] fwd
);

    logic m_hit;
    logic w_hit;

    assign m_hit = m_regwrite & (m_rd != 5'd0) & (m_rd == rs);
    assign w_hit = w_regwrite & (w_rd != 5'd0) & (w_rd == rs);

    always_comb begin
        fwd = FWD_REG;
        if (valid) begin
            if (m_hit)
                fwd = FWD_MEM;
            else if (w_hit)
                fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles,
// operand forwarding selects and a saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            d_valid,
    input  ctrl_t           d_ctrl,
    input  logic [XLEN-1:0] d_rd1,
    input  logic [XLEN-1:0] d_rd2,
    input  logic [XLEN-1:0] d_imm,
    input  logic [XLEN-1:0] d_pc,
    input  logic [4:0]      d_rs1,
    input  logic [4:0]      d_rs2,
    input  logic [4:0]      d_rd,
    input  logic [2:0]      d_funct3,
    input  logic            flush_e,
    input  logic [4:0]      m_rd,
    input  logic [4:0]      w_rd,
    input  logic            m_regwrite,
    input  logic            w_regwrite,
    output logic            e_valid,
    output ctrl_t           e_ctrl,
    output logic [XLEN-1:0] e_rd1,
    output logic [XLEN-1:0] e_rd2,
    output logic [XLEN-1:0] e_imm,
    output logic [XLEN-1:0] e_pc,
    output logic [4:0]      e_rs1,
    output logic [4:0]      e_rs2,
    output logic [4:0]      e_rd,
    output logic [2:0]      e_funct3,
    output logic            stall_fd,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [CNTW-1:0] bubble_cnt
);

    logic hazard;
    logic bubble;
    logic cnt_inc;

    // Both sources are compared whatever the format; a false stall is harmless.
    assign hazard = e_valid & e_ctrl.resultsrc & (e_rd != 5'd0) & d_valid
                  & ((e_rd == d_rs1) | (e_rd == d_rs2));

    assign stall_fd = hazard & ~flush_e;
    assign bubble   = flush_e | hazard;
    assign cnt_inc  = bubble & d_valid & (bubble_cnt != {CNTW{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid  <= 1'b0;
            e_ctrl   <= '0;
            e_rd1    <= '0;
            e_rd2    <= '0;
            e_imm    <= '0;
            e_pc     <= '0;
            e_rs1    <= '0;
            e_rs2    <= '0;
            e_rd     <= '0;
            e_funct3 <= '0;
        end else if (bubble) begin
            e_valid  <= 1'b0;
            e_ctrl   <= '0;
            e_rd1    <= '0;
            e_rd2    <= '0;
            e_imm    <= '0;
            e_pc     <= '0;
            e_rs1    <= '0;
            e_rs2    <= '0;
            e_rd     <= '0;
            e_funct3 <= '0;
        end else begin
            e_valid  <= d_valid;
            e_ctrl   <= d_valid ? d_ctrl : '0;
            e_rd1    <= d_rd1;
            e_rd2    <= d_rd2;
            e_imm    <= d_imm;
            e_pc     <= d_pc;
            e_rs1    <= d_rs1;
            e_rs2    <= d_rs2;
            e_rd     <= d_rd;
            e_funct3 <= d_funct3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_cnt <= '0;
        else if (cnt_inc)
            bubble_cnt <= bubble_cnt + CNTW'(1);
    end

    fwd_unit u_fwd_a (
        .valid      (e_valid),
        .rs         (e_rs1),
        .m_rd       (m_rd),
        .m_regwrite (m_regwrite),
        .w_rd       (w_rd),
        .w_regwrite (w_regwrite),
        .fwd        (fwd_a)
    );

    fwd_unit u_fwd_b (
        .valid      (e_valid),
        .rs         (e_rs2),
        .m_rd       (m_rd),
        .m_regwrite (m_regwrite),
        .w_rd       (w_rd),
        .w_regwrite (w_regwrite),
        .fwd        (fwd_b)
    );

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: scoreboard of expected EX contents
// plus a forwarding vector table and hand-written corner sequences.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_valid;
    ctrl_t       d_ctrl;
    logic [31:0] d_rd1, d_rd2, d_imm, d_pc;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [2:0]  d_funct3;
    logic        flush_e;
    logic [4:0]  m_rd, w_rd;
    logic        m_regwrite, w_regwrite;
    logic        e_valid;
    ctrl_t       e_ctrl;
    logic [31:0] e_rd1, e_rd2, e_imm, e_pc;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [2:0]  e_funct3;
    logic        stall_fd;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] bubble_cnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_ctrl(d_ctrl),
        .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm), .d_pc(d_pc),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_funct3(d_funct3),
        .flush_e(flush_e), .m_rd(m_rd), .w_rd(w_rd),
        .m_regwrite(m_regwrite), .w_regwrite(w_regwrite),
        .e_valid(e_valid), .e_ctrl(e_ctrl), .e_rd1(e_rd1), .e_rd2(e_rd2),
        .e_imm(e_imm), .e_pc(e_pc), .e_rs1(e_rs1), .e_rs2(e_rs2),
        .e_rd(e_rd), .e_funct3(e_funct3), .stall_fd(stall_fd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .bubble_cnt(bubble_cnt)
    );

    typedef struct packed {
        logic        valid;
        ctrl_t       ctrl;
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  funct3;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic [4:0] m_rd;
        logic       m_rw;
        logic [4:0] w_rd;
        logic       w_rw;
        logic [1:0] ea;
        logic [1:0] eb;
    } fvec_t;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t q[$];
    exp_t mx;

    localparam ctrl_t C_LOAD = '{alucontrol: 4'd0, regwrite: 1'b1,
        alusrc: 1'b1, memwrite: 1'b0, wdsel: 1'b0, resultsrc: 1'b1};
    localparam ctrl_t C_ADD = '{alucontrol: 4'd2, regwrite: 1'b1,
        alusrc: 1'b0, memwrite: 1'b0, wdsel: 1'b1, resultsrc: 1'b0};
    localparam ctrl_t C_STORE = '{alucontrol: 4'd0, regwrite: 1'b0,
        alusrc: 1'b1, memwrite: 1'b1, wdsel: 1'b0, resultsrc: 1'b0};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_total++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic set_d(input logic v, input ctrl_t c, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
        d_valid  = v;
        d_ctrl   = c;
        d_rs1    = rs1;
        d_rs2    = rs2;
        d_rd     = rd;
        d_rd1    = $urandom;
        d_rd2    = $urandom;
        d_imm    = $urandom;
        d_pc     = $urandom;
        d_funct3 = 3'($urandom_range(0, 7));
    endtask

    // One clock: predict, check stall, push expectation, clock, pop and compare.
    task automatic step(input logic full);
        exp_t e;
        exp_t got;
        logic hz;
        #1;
        hz = mx.valid & mx.ctrl.resultsrc & (mx.rd != 5'd0) & d_valid
           & (mx.rd == d_rs1 || mx.rd == d_rs2);
        if (full)
            chk("stall_fd", 64'(stall_fd), 64'(hz & ~flush_e));
        e = '0;
        if (flush_e || hz) begin
            e.cnt = mx.cnt;
            if (d_valid && mx.cnt != 16'hFFFF)
                e.cnt = mx.cnt + 16'd1;
        end else begin
            e.valid  = d_valid;
            e.ctrl   = d_valid ? d_ctrl : '0;
            e.rd1    = d_rd1;
            e.rd2    = d_rd2;
            e.imm    = d_imm;
            e.pc     = d_pc;
            e.rs1    = d_rs1;
            e.rs2    = d_rs2;
            e.rd     = d_rd;
            e.funct3 = d_funct3;
            e.cnt    = mx.cnt;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            got = q.pop_front();
            chk("bubble_cnt", 64'(bubble_cnt), 64'(got.cnt));
            if (full) begin
                chk("e_valid", 64'(e_valid), 64'(got.valid));
                chk("e_ctrl", 64'(e_ctrl), 64'(got.ctrl));
                chk("e_rd1", 64'(e_rd1), 64'(got.rd1));
                chk("e_rd2", 64'(e_rd2), 64'(got.rd2));
                chk("e_imm", 64'(e_imm), 64'(got.imm));
                chk("e_pc", 64'(e_pc), 64'(got.pc));
                chk("e_rs1", 64'(e_rs1), 64'(got.rs1));
                chk("e_rs2", 64'(e_rs2), 64'(got.rs2));
                chk("e_rd", 64'(e_rd), 64'(got.rd));
                chk("e_funct3", 64'(e_funct3), 64'(got.funct3));
            end
            mx = got;
        end
    endtask

    fvec_t fv[7];

    initial begin
        fv[0] = '{5'd7, 1'b1, 5'd7, 1'b1, FWD_MEM, FWD_REG};
        fv[1] = '{5'd7, 1'b0, 5'd7, 1'b1, FWD_WB,  FWD_REG};
        fv[2] = '{5'd3, 1'b1, 5'd7, 1'b1, FWD_WB,  FWD_MEM};
        fv[3] = '{5'd7, 1'b0, 5'd7, 1'b0, FWD_REG, FWD_REG};
        fv[4] = '{5'd3, 1'b1, 5'd3, 1'b1, FWD_REG, FWD_MEM};
        fv[5] = '{5'd9, 1'b1, 5'd3, 1'b1, FWD_REG, FWD_WB};
        fv[6] = '{5'd7, 1'b1, 5'd3, 1'b1, FWD_MEM, FWD_WB};

        rst_n = 1'b0;
        flush_e = 1'b0;
        m_rd = 5'd0; w_rd = 5'd0;
        m_regwrite = 1'b0; w_regwrite = 1'b0;
        set_d(1'b0, '0, 5'd0, 5'd0, 5'd0);
        mx = '0;
        #2;
        chk("reset_e_valid", 64'(e_valid), 64'd0);
        chk("reset_e_ctrl", 64'(e_ctrl), 64'd0);
        chk("reset_bubble_cnt", 64'(bubble_cnt), 64'd0);
        chk("reset_stall_fd", 64'(stall_fd), 64'd0);
        chk("reset_fwd", 64'({fwd_a, fwd_b}), 64'd0);
        #10 rst_n = 1'b1;

        // Forwarding table on a captured instruction with rs1=7, rs2=3.
        set_d(1'b1, C_ADD, 5'd7, 5'd3, 5'd9);
        step(1'b1);
        for (int i = 0; i < 7; i++) begin
            m_rd = fv[i].m_rd; m_regwrite = fv[i].m_rw;
            w_rd = fv[i].w_rd; w_regwrite = fv[i].w_rw;
            #1;
            chk($sformatf("fwd_a[%0d]", i), 64'(fwd_a), 64'(fv[i].ea));
            chk($sformatf("fwd_b[%0d]", i), 64'(fwd_b), 64'(fv[i].eb));
        end

        // Invalid capture keeps indices but must not forward or act.
        m_rd = 5'd7; m_regwrite = 1'b1; w_rd = 5'd3; w_regwrite = 1'b1;
        set_d(1'b0, C_STORE, 5'd7, 5'd3, 5'd4);
        step(1'b1);
        chk("fwd_invalid", 64'({fwd_a, fwd_b}), 64'd0);
        m_regwrite = 1'b0; w_regwrite = 1'b0;

        // Load-use: lw x5 then add rs1=5.
        set_d(1'b1, C_LOAD, 5'd1, 5'd0, 5'd5);
        step(1'b1);
        set_d(1'b1, C_ADD, 5'd5, 5'd6, 5'd8);
        step(1'b1);
        chk("lu_bubble", 64'(e_valid), 64'd0);
        step(1'b1);
        chk("lu_add_in_ex", 64'({e_valid, e_rs1}), 64'({1'b1, 5'd5}));
        chk("lu_cnt", 64'(bubble_cnt), 64'd1);

        // Hazard via rs2 only.
        set_d(1'b1, C_LOAD, 5'd1, 5'd0, 5'd12);
        step(1'b1);
        set_d(1'b1, C_STORE, 5'd2, 5'd12, 5'd0);
        step(1'b1);
        step(1'b1);

        // Load to x0 never stalls; x0 never forwards.
        set_d(1'b1, C_LOAD, 5'd1, 5'd0, 5'd0);
        step(1'b1);
        set_d(1'b1, C_ADD, 5'd0, 5'd0, 5'd8);
        step(1'b1);
        m_rd = 5'd0; m_regwrite = 1'b1; w_rd = 5'd0; w_regwrite = 1'b1;
        #1;
        chk("x0_fwd", 64'({fwd_a, fwd_b}), 64'd0);
        m_regwrite = 1'b0; w_regwrite = 1'b0;

        // Flush together with a hazard: one bubble, counted once.
        set_d(1'b1, C_LOAD, 5'd1, 5'd0, 5'd5);
        step(1'b1);
        set_d(1'b1, C_ADD, 5'd5, 5'd6, 5'd8);
        flush_e = 1'b1;
        step(1'b1);
        flush_e = 1'b0;
        step(1'b1);
        chk("flush_hz_cnt", 64'(bubble_cnt), 64'd3);

        // Flush with no valid instruction leaves the counter alone.
        set_d(1'b0, C_ADD, 5'd1, 5'd2, 5'd3);
        flush_e = 1'b1;
        step(1'b1);
        flush_e = 1'b0;

        // Asynchronous reset in the middle of a stall.
        set_d(1'b1, C_LOAD, 5'd1, 5'd0, 5'd5);
        step(1'b1);
        set_d(1'b1, C_ADD, 5'd5, 5'd6, 5'd8);
        #1;
        chk("pre_rst_stall", 64'(stall_fd), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(e_valid), 64'd0);
        chk("rst_mid_cnt", 64'(bubble_cnt), 64'd0);
        chk("rst_mid_stall", 64'(stall_fd), 64'd0);
        #1 rst_n = 1'b1;
        mx = '0;
        step(1'b1);
        chk("post_rst_add", 64'({e_valid, e_rd}), 64'({1'b1, 5'd8}));

        // Drive the counter to saturation with flushes.
        set_d(1'b1, C_ADD, 5'd1, 5'd2, 5'd3);
        flush_e = 1'b1;
        for (int i = 0; i < 70000 && mx.cnt != 16'hFFFF; i++)
            step(1'b0);
        chk("sat_reach", 64'(bubble_cnt), 64'hFFFF);
        step(1'b1);
        chk("sat_hold", 64'(bubble_cnt), 64'hFFFF);
        flush_e = 1'b0;
        step(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width.
REQ-002 Parameter CNTW, 16, width of bubble performance counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 d_valid  in  1  decode stage holds a real instruction.
REQ-006 d_ctrl  in  ctrl_t (9)  {alucontrol[3:0], regwrite, alusrc, memwrite, wdsel, resultsrc} from decode controller.
REQ-007 d_rd1, d_rd2, d_imm, d_pc  in  XLEN each  register-file reads, extended immediate, PC.
REQ-008 d_rs1, d_rs2, d_rd  in  5 each  source/destination register indices.
REQ-009 d_funct3  in  3  load/store size field.
REQ-010 flush_e  in  1  squash instruction entering EX (taken branch/jump).
REQ-011 m_rd, w_rd  in  5 each; m_regwrite, w_regwrite  in  1 each  MEM/WB destination info for forwarding.
REQ-012 e_valid  out  1; e_ctrl  out  ctrl_t; e_rd1, e_rd2, e_imm, e_pc  out  XLEN; e_rs1, e_rs2, e_rd  out  5; e_funct3  out  3  registered EX-stage copies.
REQ-013 stall_fd  out  1  hold PC and IF/ID register this cycle.
REQ-014 fwd_a, fwd_b  out  2  operand select: 00 register, 10 MEM result, 01 WB result.
REQ-015 bubble_cnt  out  CNTW  count of bubbles inserted.

Function
REQ-016 Load-use hazard = e_valid & e_ctrl.resultsrc & (e_rd != 0) & d_valid & (e_rd == d_rs1 | e_rd == d_rs2); both sources compared regardless of instruction format.
REQ-017 stall_fd = hazard & ~flush_e, combinational, same cycle.
REQ-018 Next-edge update priority: flush_e -> bubble; else hazard -> bubble; else capture all d_* inputs, e_valid <= d_valid.
REQ-019 Bubble = e_valid 0, e_ctrl all-zero (regwrite 0, memwrite 0); data/index fields don't-care but driven to 0.
REQ-020 Capture with d_valid 0 also zeroes e_ctrl so no architectural side effect escapes.
REQ-021 Latency: one cycle from d_* to e_*; a stalled instruction enters EX exactly one cycle after the bubble.
REQ-022 fwd_a: 10 if m_regwrite & m_rd!=0 & m_rd==e_rs1; else 01 if w_regwrite & w_rd!=0 & w_rd==e_rs1; else 00 (MEM beats WB); fwd_b identical on e_rs2; forced 00 when e_valid 0.
REQ-023 bubble_cnt increments by 1 on each edge a bubble is inserted due to hazard or flush with d_valid 1; saturates at all-ones, no wrap.
REQ-024 Simultaneous flush_e and hazard: one bubble, counted once, stall_fd 0.

Reset
REQ-025 rst_n low asynchronously clears e_valid, e_ctrl, all e_* fields, bubble_cnt to 0; stall_fd and fwd_* are then 0/00 via REQ-017/022.
REQ-026 Reset asserted mid-stall discards the held instruction state in EX; first edge after release captures d_* normally.

Structure
REQ-027 ctrl_t packed struct, FWD_REG/FWD_MEM/FWD_WB constants, and XLEN default live in the shared pipeline package.
REQ-028 Forwarding logic is one sub-module, fwd_unit, instantiated twice (A and B); hazard detection and register stay in id_ex_stage.

Verification
REQ-029 Reset: rst_n low mid-cycle with e_valid 1 -> e_valid 0, bubble_cnt 0 immediately, before next clk.
REQ-030 Load-use: EX lw x5 (resultsrc 1, e_rd 5), D add rs1=5 -> stall_fd 1 one cycle, next EX e_valid 0, following cycle EX holds add, bubble_cnt 1.
REQ-031 x0 load: EX load e_rd 0, D rs1=0 -> stall_fd 0, add captured next edge.
REQ-032 Forward priority: e_rs1=7, m_rd=7, w_rd=7, both regwrite 1 -> fwd_a 10; m_regwrite 0 -> fwd_a 01.
REQ-033 Flush+hazard same cycle -> stall_fd 0, one bubble, bubble_cnt +1 only.
REQ-034 Saturation: preload bubble_cnt 0xFFFF via 65535 bubbles, one more flush -> bubble_cnt stays 0xFFFF.
